// File: rtl/full_adder_pipe_if.sv
// ============================================================================
// Module      : full_adder_pipe_if
// Description : Operand/result bundle for full_adder_pipe. The optional ovf
//               signal exists only when FULL_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface full_adder_pipe_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             cout;
    logic [WIDTH-1:0] sum;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf;
`endif

    // Producer side: drives operands, observes the registered result.
    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        input  out_valid,
        input  cout,
        input  sum
`ifdef FULL_ADDER_OVF_EN
        ,
        input  ovf
`endif
    );

    // Adder side: consumes operands, drives the registered result.
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        output out_valid,
        output cout,
        output sum
`ifdef FULL_ADDER_OVF_EN
        ,
        output ovf
`endif
    );
endinterface

`default_nettype wire

// File: rtl/full_adder_pipe.sv
// ============================================================================
// Module      : full_adder_pipe
// Description : Registered WIDTH-bit ripple-carry adder, 1-cycle latency,
//               valid-qualified. Define FULL_ADDER_OVF_EN to add a registered
//               two's-complement overflow flag (ovf).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_pipe #(
    parameter int WIDTH = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    full_adder_pipe_if.slave   bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum_bits[i]  = bus.a[i] ^ bus.b[i] ^ carry[i];
        assign carry[i+1]   = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
    end

    logic             valid_q, valid_d;
    logic             cout_q,  cout_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf_q,   ovf_d;
`endif

    // Result registers only load on a valid beat, so idle operands (even X)
    // never reach the outputs.
    always_comb begin
        valid_d = bus.in_valid;
        cout_d  = cout_q;
        sum_d   = sum_q;
`ifdef FULL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (bus.in_valid) begin
            cout_d = carry[WIDTH];
            sum_d  = sum_bits;
`ifdef FULL_ADDER_OVF_EN
            ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
`ifdef FULL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            cout_q  <= cout_d;
            sum_q   <= sum_d;
`ifdef FULL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.cout      = cout_q;
    assign bus.sum       = sum_q;
`ifdef FULL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_full_adder_pipe.sv
// ============================================================================
// Module      : tb_full_adder_pipe
// Description : Directed/table-driven bench for full_adder_pipe at WIDTH=1
//               and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_full_adder_pipe;

    logic clk;
    logic rst_n;

    full_adder_pipe_if #(.WIDTH(1)) if1 ();
    full_adder_pipe_if #(.WIDTH(8)) if8 ();

    full_adder_pipe #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    full_adder_pipe #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       a;
        logic       b;
        logic       cin;
        logic [1:0] exp;   // {cout,sum}
    } v1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;   // {cout,sum}
    } v8_t;

    v1_t tt[8];
    v8_t bt[4];

    function automatic logic ovf_model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (s > 127) || (s < -128);
    endfunction

    initial begin
        logic [8:0] exp9;
        logic [7:0] ra, rb;
        logic       rc;

        tt[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        tt[1] = '{1'b1, 1'b0, 1'b0, 2'b01};
        tt[2] = '{1'b1, 1'b1, 1'b0, 2'b10};
        tt[3] = '{1'b0, 1'b1, 1'b0, 2'b01};
        tt[4] = '{1'b0, 1'b0, 1'b1, 2'b01};
        tt[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
        tt[6] = '{1'b1, 1'b1, 1'b1, 2'b11};
        tt[7] = '{1'b0, 1'b1, 1'b1, 2'b10};

        bt[0] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        bt[1] = '{8'hFF, 8'h00, 1'b1, 9'h100};
        bt[2] = '{8'h0F, 8'h01, 1'b0, 9'h010};
        bt[3] = '{8'h00, 8'h00, 1'b0, 9'h000};

        rst_n = 1'b0;
        if1.in_valid = 1'b0; if1.a = 1'b0;  if1.b = 1'b0;  if1.cin = 1'b0;
        if8.in_valid = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;

        // Reset state
        repeat (2) step();
        check("reset_w1", {if1.out_valid, if1.cout, if1.sum}, 3'b000);
        check("reset_w8", {if8.out_valid, if8.cout, if8.sum}, 10'h000);
        rst_n = 1'b1;

        // WIDTH=1 truth table, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            if1.in_valid = 1'b1;
            if1.a = tt[i].a; if1.b = tt[i].b; if1.cin = tt[i].cin;
            step();
            check($sformatf("tt_w1[%0d]", i), {if1.out_valid, if1.cout, if1.sum}, {1'b1, tt[i].exp});
`ifdef FULL_ADDER_OVF_EN
            check($sformatf("tt_ovf_w1[%0d]", i), if1.ovf, tt[i].exp[1] ^ tt[i].cin);
`endif
        end

        // Asynchronous reset between edges
        if1.a = 1'b1; if1.b = 1'b0; if1.cin = 1'b0;
        step();
        check("pre_reset_w1", {if1.out_valid, if1.cout, if1.sum}, 3'b101);
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_w1", {if1.out_valid, if1.cout, if1.sum}, 3'b000);
        step();
        check("held_reset_w1", {if1.out_valid, if1.cout, if1.sum}, 3'b000);
        #2 rst_n = 1'b1;
        #1;
        check("post_release_w1", {if1.out_valid, if1.cout, if1.sum}, 3'b000);
        step();
        check("first_capture_w1", {if1.out_valid, if1.cout, if1.sum}, 3'b111);

        // Hold on idle: 1+1+0, then three idle cycles with wiggling operands
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b0;
        step();
        check("hold_load_w1", {if1.out_valid, if1.cout, if1.sum}, 3'b110);
        for (int i = 0; i < 3; i++) begin
            if1.in_valid = 1'b0;
            if (i == 1) begin
                if1.a = 1'bx; if1.b = 1'bx; if1.cin = 1'bx;
            end else begin
                if1.a = ~i[0]; if1.b = i[0]; if1.cin = 1'b1;
            end
            step();
            check($sformatf("hold_idle_w1[%0d]", i), {if1.out_valid, if1.cout, if1.sum}, 3'b010);
        end
        if1.a = 1'b0; if1.b = 1'b0; if1.cin = 1'b0;

        // WIDTH=8 boundaries
        for (int i = 0; i < 4; i++) begin
            if8.in_valid = 1'b1;
            if8.a = bt[i].a; if8.b = bt[i].b; if8.cin = bt[i].cin;
            step();
            check($sformatf("bound_w8[%0d]", i), {if8.out_valid, if8.cout, if8.sum}, {1'b1, bt[i].exp});
        end

        // WIDTH=8 back-to-back random stream
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            if8.in_valid = 1'b1;
            if8.a = ra; if8.b = rb; if8.cin = rc;
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            step();
            check($sformatf("rand_w8[%0d]", i), {if8.out_valid, if8.cout, if8.sum}, {1'b1, exp9});
`ifdef FULL_ADDER_OVF_EN
            check($sformatf("rand_ovf_w8[%0d]", i), if8.ovf, ovf_model8(ra, rb, rc));
`endif
        end
        if8.in_valid = 1'b0;
        step();
        check("idle_after_stream_w8", {if8.out_valid, if8.cout, if8.sum}, {1'b0, exp9});

`ifdef FULL_ADDER_OVF_EN
        // Signed overflow corner cases: {ovf,cout,sum}
        if8.in_valid = 1'b1; if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0;
        step();
        check("ovf_7f_01", {if8.ovf, if8.cout, if8.sum}, {1'b1, 1'b0, 8'h80});
        if8.a = 8'h80; if8.b = 8'h80; if8.cin = 1'b0;
        step();
        check("ovf_80_80", {if8.ovf, if8.cout, if8.sum}, {1'b1, 1'b1, 8'h00});
        if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0;
        step();
        check("ovf_01_01", {if8.ovf, if8.cout, if8.sum}, {1'b0, 1'b0, 8'h02});
        if8.in_valid = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
